// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle logic/arith ops, iterative shift-add multiply and
// optional restoring divide (enabled by defining MULTICYCLE_ALU_DIV_EN).
module multicycle_alu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       aluctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] aluOut,
  output logic             zero,
  output logic             LSb_aluresult,
  output logic             div_by_zero
);

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_MUL  = 4'd4;
  localparam logic [3:0] OP_DIVU = 4'd5;
  localparam logic [3:0] OP_REMU = 4'd6;
  localparam logic [3:0] OP_SUB  = 4'd10;
  localparam logic [3:0] OP_SLTU = 4'd11;
  localparam logic [3:0] OP_SLT  = 4'd12;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DONE
`ifdef MULTICYCLE_ALU_DIV_EN
    , S_DIV
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] simple_res;

`ifdef MULTICYCLE_ALU_DIV_EN
  logic             rem_sel_q, rem_sel_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_diff;
  logic             q_bit;
`endif

  always_comb begin
    simple_res = '0;
    case (aluctrl)
      OP_AND:  simple_res = a & b;
      OP_OR:   simple_res = a | b;
      OP_ADD:  simple_res = a + b;
      OP_SUB:  simple_res = a - b;
      OP_SLTU: simple_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLT:  simple_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: simple_res = '0;
    endcase
  end

`ifdef MULTICYCLE_ALU_DIV_EN
  // One restoring step: shift the next dividend bit into the partial remainder.
  always_comb begin
    rem_sh   = {acc_q, x_q[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, y_q};
    q_bit    = ~rem_diff[WIDTH];
  end
`endif

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    acc_d   = acc_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
`ifdef MULTICYCLE_ALU_DIV_EN
    rem_sel_d = rem_sel_q;
    dbz_d     = dbz_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          x_d   = a;
          y_d   = b;
          acc_d = '0;
          cnt_d = '0;
          if (aluctrl == OP_MUL) begin
            state_d = S_MUL;
`ifdef MULTICYCLE_ALU_DIV_EN
          end else if (aluctrl == OP_DIVU || aluctrl == OP_REMU) begin
            rem_sel_d = (aluctrl == OP_REMU);
            state_d   = S_DIV;
`endif
          end else begin
            res_d   = simple_res;
`ifdef MULTICYCLE_ALU_DIV_EN
            dbz_d   = 1'b0;
`endif
            state_d = S_DONE;
          end
        end
      end
      S_MUL: begin
        if (y_q[0]) acc_d = acc_q + x_q;
        x_d   = x_q << 1;
        y_d   = y_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          res_d   = acc_d;
`ifdef MULTICYCLE_ALU_DIV_EN
          dbz_d   = 1'b0;
`endif
          state_d = S_DONE;
        end
      end
`ifdef MULTICYCLE_ALU_DIV_EN
      // A zero divisor naturally yields an all-ones quotient and remainder = a.
      S_DIV: begin
        acc_d = q_bit ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        x_d   = {x_q[WIDTH-2:0], q_bit};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          res_d   = rem_sel_q ? acc_d : x_d;
          dbz_d   = (y_q == '0);
          state_d = S_DONE;
        end
      end
`endif
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
`ifdef MULTICYCLE_ALU_DIV_EN
      rem_sel_q <= 1'b0;
      dbz_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
`ifdef MULTICYCLE_ALU_DIV_EN
      rem_sel_q <= rem_sel_d;
      dbz_q     <= dbz_d;
`endif
    end
  end

  assign in_ready      = (state_q == S_IDLE);
  assign out_valid     = (state_q == S_DONE);
  assign aluOut        = res_q;
  assign zero          = (res_q == '0);
  assign LSb_aluresult = res_q[0];
`ifdef MULTICYCLE_ALU_DIV_EN
  assign div_by_zero   = dbz_q;
`else
  assign div_by_zero   = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu (WIDTH=32): directed cases plus random
// operations compared against an arithmetic reference model.
module tb_multicycle_alu;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  aluctrl;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] aluOut;
  logic        zero;
  logic        LSb_aluresult;
  logic        div_by_zero;

  int tests = 0;
  int fails = 0;

  multicycle_alu #(.WIDTH(32), .CNT_W(6)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .a             (a),
    .b             (b),
    .aluctrl       (aluctrl),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .aluOut        (aluOut),
    .zero          (zero),
    .LSb_aluresult (LSb_aluresult),
    .div_by_zero   (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference behaviour straight from the opcode table, using wide arithmetic.
  function automatic void model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output logic dz, output int lat);
    longint unsigned prod;
    r   = 32'd0;
    dz  = 1'b0;
    lat = 1;
    case (op)
      4'd0:  r = x & y;
      4'd1:  r = x | y;
      4'd2:  r = x + y;
      4'd4: begin
        prod = longint'(x) * longint'(y);
        r    = prod[31:0];
        lat  = 33;
      end
`ifdef MULTICYCLE_ALU_DIV_EN
      4'd5: begin
        r   = (y == 0) ? 32'hFFFF_FFFF : x / y;
        dz  = (y == 0);
        lat = 33;
      end
      4'd6: begin
        r   = (y == 0) ? x : x % y;
        dz  = (y == 0);
        lat = 33;
      end
`endif
      4'd10: r = x - y;
      4'd11: r = (x < y) ? 32'd1 : 32'd0;
      4'd12: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      default: r = 32'd0;
    endcase
  endfunction

  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                               input int hold);
    logic [31:0] er;
    logic        ed;
    int          el;
    int          lat;
    int          waitc;
    int          busyBad;
    int          holdBad;
    logic [31:0] held;
    model(op, x, y, er, ed, el);
    waitc = 0;
    while (!in_ready && waitc < 10) begin
      @(posedge clk); #1;
      waitc++;
    end
    checkOutput("idle_in_ready", 64'(in_ready), 64'd1);
    a = x; b = y; aluctrl = op; in_valid = 1'b1; out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom; aluctrl = 4'($urandom);
    lat = 1;
    busyBad = 0;
    while (!out_valid && lat < 100) begin
      if (in_ready) busyBad++;
      in_valid = 1'($urandom_range(0, 1));
      a = $urandom; b = $urandom; aluctrl = 4'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    checkOutput("latency", 64'(lat), 64'(el));
    checkOutput("busy_in_ready", 64'(busyBad), 64'd0);
    checkOutput("done_in_ready", 64'(in_ready), 64'd0);
    checkOutput("aluOut", 64'(aluOut), 64'(er));
    checkOutput("zero", 64'(zero), 64'(er == 32'd0));
    checkOutput("lsb", 64'(LSb_aluresult), 64'(er[0]));
    checkOutput("div_by_zero", 64'(div_by_zero), 64'(ed));
    if (hold > 0) begin
      held = aluOut;
      holdBad = 0;
      repeat (hold) begin
        in_valid = 1'b1; a = $urandom; aluctrl = 4'($urandom);
        @(posedge clk); #1;
        if (!out_valid || aluOut !== held || in_ready) holdBad++;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      checkOutput("hold_stable", 64'(holdBad), 64'd0);
    end
    @(posedge clk); #1;
    checkOutput("release_valid", 64'(out_valid), 64'd0);
    checkOutput("release_ready", 64'(in_ready), 64'd1);
  endtask

  logic [3:0] opList [12] = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd10, 4'd11, 4'd12, 4'd3, 4'd7, 4'd15};

  initial begin
    logic [31:0] rx;
    logic [31:0] ry;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; aluctrl = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_aluOut", 64'(aluOut), 64'd0);
    checkOutput("rst_zero", 64'(zero), 64'd1);
    checkOutput("rst_lsb", 64'(LSb_aluresult), 64'd0);
    checkOutput("rst_dbz", 64'(div_by_zero), 64'd0);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    reset = 1'b0;

    applyStimulus(4'd2, 32'd5, 32'hFFFF_FFFD, 0);
    applyStimulus(4'd4, 32'h0001_0000, 32'h0001_0001, 0);
    applyStimulus(4'd5, 32'd100, 32'd7, 0);
    applyStimulus(4'd6, 32'd100, 32'd7, 0);
    applyStimulus(4'd5, 32'd9, 32'd0, 0);
    applyStimulus(4'd6, 32'd9, 32'd0, 0);
    applyStimulus(4'd12, 32'hFFFF_FFFF, 32'd1, 0);
    applyStimulus(4'd11, 32'hFFFF_FFFF, 32'd1, 0);
    applyStimulus(4'd10, 32'd7, 32'd7, 0);
    applyStimulus(4'd1, 32'hA5A5_0000, 32'h0000_5A5B, 10);
    applyStimulus(4'd4, 32'h1234_5678, 32'h9ABC_DEF1, 10);

    // Abort a multiply part-way through with reset.
    a = 32'h0000_FFFF; b = 32'h0000_FFFF; aluctrl = 4'd4; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    in_valid = 1'b0;
    checkOutput("abort_out_valid", 64'(out_valid), 64'd0);
    checkOutput("abort_aluOut", 64'(aluOut), 64'd0);
    checkOutput("abort_in_ready", 64'(in_ready), 64'd1);
    applyStimulus(4'd4, 32'd3, 32'd4, 0);

    for (int i = 0; i < 40; i++) begin
      rx = $urandom;
      ry = $urandom;
      if ($urandom_range(0, 3) == 0) ry = ry & 32'hFF;
      if ($urandom_range(0, 7) == 0) ry = 32'd0;
      if ($urandom_range(0, 7) == 0) rx = ry;
      applyStimulus(opList[$urandom_range(0, 11)], rx, ry, int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
